// File: rtl/sram_lsu_if.sv
// Bundle of core request/response handshake and SRAM initiator signals for sram_lsu.
// The slave modport is the LSU view; the master modport is the core/SRAM environment view.
interface sram_lsu_if #(
   parameter int ADDR_WIDTH = 10
) ();
   logic                  i_req_valid;
   logic                  o_req_ready;
   logic                  i_req_we;
   logic [2:0]            i_req_funct3;
   logic [31:0]           i_req_addr;
   logic [31:0]           i_req_wdata;
   logic                  o_rsp_valid;
   logic                  i_rsp_ready;
   logic [31:0]           o_rsp_rdata;
   logic                  o_rsp_err;
   logic [ADDR_WIDTH-1:0] o_sram_addr;
   logic [31:0]           o_sram_data;
   logic                  o_sram_cs;
   logic [31:0]           o_sram_we;
   logic [31:0]           i_sram_data;

   modport slave (
      input  i_req_valid, i_req_we, i_req_funct3, i_req_addr, i_req_wdata,
      input  i_rsp_ready, i_sram_data,
      output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
      output o_sram_addr, o_sram_data, o_sram_cs, o_sram_we
   );

   modport master (
      output i_req_valid, i_req_we, i_req_funct3, i_req_addr, i_req_wdata,
      output i_rsp_ready, i_sram_data,
      input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
      input  o_sram_addr, o_sram_data, o_sram_cs, o_sram_we
   );
endinterface

// File: rtl/sram_lsu.sv
// RISC-V byte/half/word load-store unit driving a single-port SRAM with bit-masked writes
// and a 1-cycle registered read; one request in flight, IDLE -> ACCESS -> RESP.
module sram_lsu #(
   parameter int ADDR_WIDTH = 10
) (
   input logic       i_clk,
   input logic       i_rst,
   sram_lsu_if.slave bus
);
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   state_t                state_r, state_nxt_s;
   logic                  we_r, err_r, cs_r;
   logic [2:0]            funct3_r;
   logic [1:0]            off_r;
   logic [ADDR_WIDTH-1:0] addr_r;
   logic [31:0]           data_r, mask_r;
   logic                  accept_s, funct3_bad_s, misalign_s, range_bad_s, req_err_s;
   logic [31:0]           st_mask_s, st_data_s, rdata_s;
   logic [7:0]            byte_s;
   logic [15:0]           half_s;

   assign accept_s = bus.i_req_valid && (state_r == ST_IDLE);

   // Request legality: funct3 per direction, natural alignment, address inside the SRAM.
   always_comb begin
      funct3_bad_s = 1'b0;
      if (bus.i_req_we) begin
         funct3_bad_s = (bus.i_req_funct3 >= 3'd3);
      end else begin
         funct3_bad_s = (bus.i_req_funct3 == 3'b011) || (bus.i_req_funct3[2:1] == 2'b11);
      end
      misalign_s  = ((bus.i_req_funct3[1:0] == 2'b01) && bus.i_req_addr[0]) ||
                    ((bus.i_req_funct3[1:0] == 2'b10) && (bus.i_req_addr[1:0] != 2'b00));
      range_bad_s = |bus.i_req_addr[31:ADDR_WIDTH+2];
      req_err_s   = funct3_bad_s || misalign_s || range_bad_s;
   end

   // Store lane mask and lane-replicated data so every lane carries the right bytes.
   always_comb begin
      st_mask_s = 32'h0000_0000;
      st_data_s = 32'h0000_0000;
      case (bus.i_req_funct3[1:0])
         2'b00: begin
            st_mask_s = 32'h0000_00FF << {bus.i_req_addr[1:0], 3'b000};
            st_data_s = {4{bus.i_req_wdata[7:0]}};
         end
         2'b01: begin
            if (bus.i_req_addr[1]) begin
               st_mask_s = 32'hFFFF_0000;
            end else begin
               st_mask_s = 32'h0000_FFFF;
            end
            st_data_s = {2{bus.i_req_wdata[15:0]}};
         end
         2'b10: begin
            st_mask_s = 32'hFFFF_FFFF;
            st_data_s = bus.i_req_wdata;
         end
         default: begin
            st_mask_s = 32'h0000_0000;
            st_data_s = 32'h0000_0000;
         end
      endcase
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_nxt_s = req_err_s ? ST_RESP : ST_ACCESS;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ACCESS: state_nxt_s = ST_RESP;
         ST_RESP: begin
            if (bus.i_rsp_ready) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_RESP;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State register, latched request fields and registered SRAM controls.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_r  <= ST_IDLE;
         we_r     <= 1'b0;
         err_r    <= 1'b0;
         funct3_r <= 3'b000;
         off_r    <= 2'b00;
         cs_r     <= 1'b0;
         addr_r   <= '0;
         data_r   <= 32'h0000_0000;
         mask_r   <= 32'h0000_0000;
      end else begin
         state_r <= state_nxt_s;
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  we_r     <= bus.i_req_we;
                  funct3_r <= bus.i_req_funct3;
                  off_r    <= bus.i_req_addr[1:0];
                  err_r    <= req_err_s;
                  if (!req_err_s) begin
                     cs_r   <= 1'b1;
                     addr_r <= bus.i_req_addr[ADDR_WIDTH+1:2];
                     data_r <= bus.i_req_we ? st_data_s : 32'h0000_0000;
                     mask_r <= bus.i_req_we ? st_mask_s : 32'h0000_0000;
                  end
               end
            end
            ST_ACCESS: begin
               cs_r   <= 1'b0;
               mask_r <= 32'h0000_0000;
            end
            default: ;
         endcase
      end
   end

   // Load alignment and extension from the read word, held stable while cs is low.
   always_comb begin
      case (off_r)
         2'd0:    byte_s = bus.i_sram_data[7:0];
         2'd1:    byte_s = bus.i_sram_data[15:8];
         2'd2:    byte_s = bus.i_sram_data[23:16];
         2'd3:    byte_s = bus.i_sram_data[31:24];
         default: byte_s = bus.i_sram_data[7:0];
      endcase
      if (off_r[1]) begin
         half_s = bus.i_sram_data[31:16];
      end else begin
         half_s = bus.i_sram_data[15:0];
      end
      rdata_s = 32'h0000_0000;
      if ((state_r == ST_RESP) && !we_r && !err_r) begin
         case (funct3_r)
            3'b000:  rdata_s = {{24{byte_s[7]}}, byte_s};
            3'b001:  rdata_s = {{16{half_s[15]}}, half_s};
            3'b010:  rdata_s = bus.i_sram_data;
            3'b100:  rdata_s = {24'h00_0000, byte_s};
            3'b101:  rdata_s = {16'h0000, half_s};
            default: rdata_s = 32'h0000_0000;
         endcase
      end else begin
         rdata_s = 32'h0000_0000;
      end
   end

   assign bus.o_req_ready = (state_r == ST_IDLE);
   assign bus.o_rsp_valid = (state_r == ST_RESP);
   assign bus.o_rsp_err   = (state_r == ST_RESP) && err_r;
   assign bus.o_rsp_rdata = rdata_s;
   assign bus.o_sram_cs   = cs_r;
   assign bus.o_sram_addr = addr_r;
   assign bus.o_sram_data = data_r;
   assign bus.o_sram_we   = mask_r;
endmodule

// File: tb/tb_sram_lsu.sv
// Directed scoreboard bench for sram_lsu: stimulus pushes expected responses and SRAM
// accesses into queues, and a negedge monitor pops and compares them.
module tb_sram_lsu;
   localparam int AW = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   logic [32:0]      rsp_q[$];
   logic [AW+63:0]   sram_q[$];
   logic [31:0]      mem [0:(1<<AW)-1];
   logic [31:0]      sram_rd_r = 32'h0000_0000;

   sram_lsu_if #(.ADDR_WIDTH(AW)) bus ();

   sram_lsu #(.ADDR_WIDTH(AW)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   assign bus.i_sram_data = sram_rd_r;

   // SRAM model: masked write and registered read on the edge that ends the access.
   always @(posedge clk) begin
      if (bus.o_sram_cs) begin
         mem[bus.o_sram_addr] <= (mem[bus.o_sram_addr] & ~bus.o_sram_we) |
                                 (bus.o_sram_data & bus.o_sram_we);
         sram_rd_r <= mem[bus.o_sram_addr];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Monitor: compare every response handshake and every SRAM access against the queues.
   always @(negedge clk) begin
      logic [32:0]    re;
      logic [AW+63:0] se;
      if (!rst && bus.o_rsp_valid && bus.i_rsp_ready) begin
         if (rsp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rsp_unexpected actual_rdata=%h err=%0d", bus.o_rsp_rdata, bus.o_rsp_err);
         end else begin
            re = rsp_q.pop_front();
            chk("rsp_err", 32'(bus.o_rsp_err), 32'(re[32]));
            chk("rsp_rdata", bus.o_rsp_rdata, re[31:0]);
         end
      end
      if (!rst && bus.o_sram_cs) begin
         if (sram_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sram_unexpected actual_addr=%h we=%h", bus.o_sram_addr, bus.o_sram_we);
         end else begin
            se = sram_q.pop_front();
            chk("sram_addr", 32'(bus.o_sram_addr), 32'(se[AW+63:64]));
            chk("sram_we", bus.o_sram_we, se[63:32]);
            chk("sram_data", bus.o_sram_data, se[31:0]);
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (!bus.o_req_ready && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("req_ready_timeout", 32'(bus.o_req_ready), 32'd1);
   endtask

   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic exp_err, input logic [31:0] exp_rdata,
                        input logic [AW-1:0] exp_addr, input logic [31:0] exp_mask,
                        input logic [31:0] exp_data);
      wait_idle();
      bus.i_req_valid  = 1'b1;
      bus.i_req_we     = we;
      bus.i_req_funct3 = f3;
      bus.i_req_addr   = addr;
      bus.i_req_wdata  = wdata;
      rsp_q.push_back({exp_err, exp_rdata});
      if (!exp_err) sram_q.push_back({exp_addr, exp_mask, exp_data});
      @(posedge clk);
      #1;
      bus.i_req_valid = 1'b0;
      @(negedge clk);
      if (exp_err) begin
         chk("err_rsp_next_cycle", 32'(bus.o_rsp_valid), 32'd1);
         chk("err_no_cs", 32'(bus.o_sram_cs), 32'd0);
      end else begin
         chk("access_cs", 32'(bus.o_sram_cs), 32'd1);
         chk("access_no_rsp", 32'(bus.o_rsp_valid), 32'd0);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, 32'(bus.o_req_ready), 32'd1);
      chk({tag, "_rsp_valid"}, 32'(bus.o_rsp_valid), 32'd0);
      chk({tag, "_rsp_rdata"}, bus.o_rsp_rdata, 32'h0000_0000);
      chk({tag, "_rsp_err"}, 32'(bus.o_rsp_err), 32'd0);
      chk({tag, "_sram_cs"}, 32'(bus.o_sram_cs), 32'd0);
      chk({tag, "_sram_we"}, bus.o_sram_we, 32'h0000_0000);
      chk({tag, "_sram_addr"}, 32'(bus.o_sram_addr), 32'd0);
      chk({tag, "_sram_data"}, bus.o_sram_data, 32'h0000_0000);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.i_req_valid  = 1'b0;
      bus.i_req_we     = 1'b0;
      bus.i_req_funct3 = 3'b000;
      bus.i_req_addr   = 32'h0000_0000;
      bus.i_req_wdata  = 32'h0000_0000;
      bus.i_rsp_ready  = 1'b1;
      rst = 1'b1;
      #12;
      chk_reset_outputs("por");
      @(negedge clk);
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // we  f3      addr           wdata          err  rdata          waddr   mask           sram data
      issue(1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 10'd4, 32'hFFFF_FFFF, 32'hDEAD_BEEF);
      issue(1'b0, 3'b010, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF, 10'd4, 32'h0000_0000, 32'h0000_0000);
      issue(1'b1, 3'b010, 32'h0000_0010, 32'h1122_3344, 1'b0, 32'h0000_0000, 10'd4, 32'hFFFF_FFFF, 32'h1122_3344);
      issue(1'b1, 3'b000, 32'h0000_0013, 32'h0000_00A5, 1'b0, 32'h0000_0000, 10'd4, 32'hFF00_0000, 32'hA5A5_A5A5);
      issue(1'b0, 3'b000, 32'h0000_0013, 32'h0000_0000, 1'b0, 32'hFFFF_FFA5, 10'd4, 32'h0000_0000, 32'h0000_0000);
      issue(1'b0, 3'b100, 32'h0000_0013, 32'h0000_0000, 1'b0, 32'h0000_00A5, 10'd4, 32'h0000_0000, 32'h0000_0000);
      issue(1'b0, 3'b010, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hA522_3344, 10'd4, 32'h0000_0000, 32'h0000_0000);
      issue(1'b1, 3'b001, 32'h0000_0012, 32'hFFFF_8001, 1'b0, 32'h0000_0000, 10'd4, 32'hFFFF_0000, 32'h8001_8001);
      issue(1'b0, 3'b001, 32'h0000_0012, 32'h0000_0000, 1'b0, 32'hFFFF_8001, 10'd4, 32'h0000_0000, 32'h0000_0000);
      issue(1'b0, 3'b101, 32'h0000_0012, 32'h0000_0000, 1'b0, 32'h0000_8001, 10'd4, 32'h0000_0000, 32'h0000_0000);
      issue(1'b0, 3'b000, 32'h0000_0011, 32'h0000_0000, 1'b0, 32'h0000_0033, 10'd4, 32'h0000_0000, 32'h0000_0000);
      issue(1'b0, 3'b001, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'h0000_3344, 10'd4, 32'h0000_0000, 32'h0000_0000);
      issue(1'b1, 3'b000, 32'h0000_0011, 32'hFFFF_FF80, 1'b0, 32'h0000_0000, 10'd4, 32'h0000_FF00, 32'h8080_8080);
      issue(1'b0, 3'b000, 32'h0000_0011, 32'h0000_0000, 1'b0, 32'hFFFF_FF80, 10'd4, 32'h0000_0000, 32'h0000_0000);
      issue(1'b1, 3'b010, 32'h0000_0FFC, 32'hCAFE_F00D, 1'b0, 32'h0000_0000, 10'd1023, 32'hFFFF_FFFF, 32'hCAFE_F00D);
      issue(1'b0, 3'b010, 32'h0000_0FFC, 32'h0000_0000, 1'b0, 32'hCAFE_F00D, 10'd1023, 32'h0000_0000, 32'h0000_0000);

      // Rejected requests: misaligned LW/SH, illegal funct3 both directions, out of range.
      issue(1'b0, 3'b010, 32'h0000_0002, 32'h0000_0000, 1'b1, 32'h0000_0000, 10'd0, 32'h0000_0000, 32'h0000_0000);
      issue(1'b1, 3'b001, 32'h0000_0001, 32'h1234_5678, 1'b1, 32'h0000_0000, 10'd0, 32'h0000_0000, 32'h0000_0000);
      issue(1'b0, 3'b011, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 10'd0, 32'h0000_0000, 32'h0000_0000);
      issue(1'b1, 3'b100, 32'h0000_0000, 32'h0000_00FF, 1'b1, 32'h0000_0000, 10'd0, 32'h0000_0000, 32'h0000_0000);
      issue(1'b0, 3'b010, 32'h0000_1000, 32'h0000_0000, 1'b1, 32'h0000_0000, 10'd0, 32'h0000_0000, 32'h0000_0000);

      // Response backpressure: response and rdata must hold, no further SRAM access.
      wait_idle();
      bus.i_rsp_ready = 1'b0;
      issue(1'b0, 3'b010, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'h8001_8044, 10'd4, 32'h0000_0000, 32'h0000_0000);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_rsp_valid", 32'(bus.o_rsp_valid), 32'd1);
         chk("bp_rsp_rdata", bus.o_rsp_rdata, 32'h8001_8044);
         chk("bp_req_ready", 32'(bus.o_req_ready), 32'd0);
         chk("bp_no_cs", 32'(bus.o_sram_cs), 32'd0);
      end
      @(posedge clk);
      #1;
      bus.i_rsp_ready = 1'b1;

      // Reset during the ACCESS cycle of a store, then a fresh load.
      wait_idle();
      issue(1'b1, 3'b010, 32'h0000_0020, 32'h1234_5678, 1'b0, 32'h0000_0000, 10'd8, 32'hFFFF_FFFF, 32'h1234_5678);
      #1;
      rst = 1'b1;
      #1;
      chk_reset_outputs("midrst");
      rsp_q.delete();
      @(negedge clk);
      #2;
      rst = 1'b0;
      issue(1'b0, 3'b010, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'h8001_8044, 10'd4, 32'h0000_0000, 32'h0000_0000);

      wait_idle();
      repeat (3) @(posedge clk);
      chk("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
      chk("sram_q_drained", 32'(sram_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sram_lsu.md
# sram_lsu

Load/store unit that acts as the initiator for the single-port synchronous SRAM (bit-masked write enable, 1-cycle registered read). It accepts RISC-V byte/half/word load and store requests from the core over a valid/ready handshake. It translates each request into one SRAM access, then returns aligned, sign- or zero-extended load data or a store acknowledgement over a valid/ready response channel. It sits between the core's MEM stage and the data SRAM instance.

## Interface
- ADDR_WIDTH, 10, SRAM word-address width; addressable range is 2^ADDR_WIDTH words (byte addresses 0 .. 4*2^ADDR_WIDTH-1). Data width is fixed at 32.
- i_clk  input  1  clock; all state changes on the rising edge.
- i_rst  input  1  reset; asynchronous, active-high.
- i_req_valid  input  1  request valid.
- o_req_ready  output  1  request ready; equals (state==IDLE).
- i_req_we  input  1  1 = store, 0 = load.
- i_req_funct3  input  3  RISC-V funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- i_req_addr  input  32  byte address.
- i_req_wdata  input  32  store data, right-aligned.
- o_rsp_valid  output  1  response valid; equals (state==RESP).
- i_rsp_ready  input  1  response accepted.
- o_rsp_rdata  output  32  load result; 0 for stores and errors.
- o_rsp_err  output  1  request was rejected: misaligned, illegal funct3, or out of range.
- o_sram_addr  output  ADDR_WIDTH  word address (i_req_addr[ADDR_WIDTH+1:2]), registered.
- o_sram_data  output  32  lane-replicated write data, registered.
- o_sram_cs  output  1  chip select, registered; high only in ACCESS.
- o_sram_we  output  32  per-bit write mask, registered; all-zero for loads.
- i_sram_data  input  32  SRAM read data.

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE:
  - On i_req_valid & o_req_ready, latch we, funct3, addr[1:0] and wdata, then check the request.
  - An error makes the next state RESP with the error flag set, and no SRAM access occurs.
  - Otherwise the next state is ACCESS, and o_sram_cs/addr/data/we are loaded on the same edge.
- Error conditions:
  - funct3 is not in the legal set for its direction (loads: 011, 110, 111; stores: 011 and above).
  - Misaligned: half access with addr[0]=1, or word access with addr[1:0]!=0.
  - Out of range: addr[31:ADDR_WIDTH+2] != 0.
- ACCESS lasts exactly 1 cycle with o_sram_cs=1. The SRAM performs the access on the edge that ends ACCESS. On that edge the outputs clear (cs=0, we=0) and the next state is RESP.
- Store mask and data:
  - SB: we = 0xFF << 8*addr[1:0]; data = {4{wdata[7:0]}}.
  - SH: we = 0xFFFF << 16*addr[1]; data = {2{wdata[15:0]}}.
  - SW: we = all ones; data = wdata.
- RESP:
  - o_rsp_valid=1, o_rsp_err = the latched flag.
  - For a load without error, o_rsp_rdata is computed combinationally from i_sram_data as follows:
    - Byte: i_sram_data[8*a+7:8*a] with a=addr[1:0]; sign-extend for LB, zero-extend for LBU.
    - Half: i_sram_data[16*h+15:16*h] with h=addr[1]; sign-extend for LH, zero-extend for LHU.
    - Word: i_sram_data unchanged.
  - i_sram_data stays stable throughout RESP because cs stays low.
  - Stay in RESP while i_rsp_ready=0. Move to IDLE on the edge where i_rsp_ready=1.

## Timing
- Request accepted at edge k → ACCESS during cycle k..k+1 → RESP from edge k+1. The earliest response handshake is at edge k+2, and the next request can be accepted at edge k+3. Sustained throughput is one request per 3 cycles with no backpressure.
- Errored request: RESP from edge k+1, with no cycle of cs=1.
- o_req_ready is low in ACCESS and RESP. There is no request queueing; the core must hold i_req_* until it is accepted.
- Reset values: state IDLE, o_req_ready=1, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0, o_sram_cs=0, o_sram_we=0, o_sram_addr=0, o_sram_data=0.
- Reset mid-operation aborts the operation immediately:
  - In ACCESS, cs/we drop asynchronously, so the write is not guaranteed.
  - In RESP, the response is discarded.
- i_req_valid arriving in the same cycle that RESP completes is not accepted until the IDLE cycle that follows.

## Test plan
- Store SW addr 0x10, wdata 0xDEADBEEF; then LW 0x10 → one ACCESS cycle with o_sram_addr=4 and we=0xFFFFFFFF; the load returns 0xDEADBEEF with err=0.
- SB 0x13 with wdata 0x000000A5 over the word 0x11223344 → we=0xFF000000, data=0xA5A5A5A5. LB 0x13 → 0xFFFFFFA5; LBU 0x13 → 0x000000A5; LW 0x10 → 0xA5223344.
- SH 0x12 with 0x8001 → we=0xFFFF0000. LH 0x12 → 0xFFFF8001; LHU 0x12 → 0x00008001.
- LW 0x02, SH 0x01, funct3=011, and addr 0x00001000 with ADDR_WIDTH=10 → each gives err=1 and rdata=0, o_sram_cs never rises, and the response comes 1 cycle after acceptance.
- Response backpressure: hold i_rsp_ready=0 for 5 cycles after LW → o_rsp_valid and rdata are held stable, o_req_ready=0, and no extra SRAM access occurs.
- Assert i_rst during ACCESS of a store, then issue a new LW → all outputs return to their reset values at once, and the new request completes normally after reset is released.
